fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS core; sits directly upstream of the control unit.
- Owns the program counter and drives the address of the asynchronous-read program memory.
- Registers the fetched word with its PC+4, and presents the opcode field OP_ID[5:0] plus the register/immediate fields to the decode stage.
- Handles stall, flush and branch/jump redirect.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (start of the text segment).
- NBITS, 32, width of PC and instruction words.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Stall  input  1  hazard unit request to hold PC and IF/ID
- Flush  input  1  replace IF/ID contents with a bubble
- BranchTaken  input  1  redirect PC to BranchTarget
- BranchTarget  input  NBITS  redirect address
- IMemData  input  NBITS  program memory read data (combinational from IMemAddr)
- IMemAddr  output  NBITS  current PC, drives program memory
- Instruction_ID  output  NBITS  registered instruction
- PCPlus4_ID  output  NBITS  registered PC+4 of that instruction
- Valid_ID  output  1  IF/ID holds a real instruction
- OP_ID  output  6  Instruction_ID[31:26], to control unit
- Rs_ID, Rt_ID, Rd_ID  output  5 each  Instruction_ID[25:21], [20:16], [15:11]
- Imm_ID  output  16  Instruction_ID[15:0]
- AlignErr  output  1  one-cycle pulse: BranchTarget[1:0] != 0 on an accepted redirect
- FetchCount  output  32  number of instructions loaded valid into IF/ID

Behaviour:
- Reset (async, while reset==0): PC=RESET_PC; Instruction_ID=0; PCPlus4_ID=0; Valid_ID=0; AlignErr=0; FetchCount=0.
  - The bubble word 32'h0000_0000 (sll $0,$0,0) decodes as R_Type writing $0, so it is architecturally a NOP.
- Reset asserted mid-operation overrides everything immediately. The first fetch after release is at RESET_PC.
- IMemAddr = PC, combinational. The instruction fetched at PC appears on Instruction_ID one clock later (latency 1).
- Per rising edge, priority BranchTaken > Flush > Stall > normal:
  - BranchTaken: PC <= {BranchTarget[NBITS-1:2],2'b00}; IF/ID <= bubble (Instruction_ID=0, PCPlus4_ID=0, Valid_ID=0). AlignErr <= |BranchTarget[1:0].
  - Flush (no BranchTaken): IF/ID <= bubble; PC holds, so the same word is refetched next cycle.
  - Stall (no BranchTaken/Flush): PC and all IF/ID registers hold, Valid_ID unchanged.
  - Normal: PC <= PC+4; Instruction_ID <= IMemData; PCPlus4_ID <= PC+4; Valid_ID <= 1.
- AlignErr is 0 on every edge that is not an accepted BranchTaken.
- BranchTaken overrides Stall in the same cycle (a redirect is never lost).
- PC arithmetic is modulo 2^NBITS: PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- FetchCount increments by 1 on each Normal edge only, and wraps at 2^32.
- OP_ID, Rs_ID, Rt_ID, Rd_ID, Imm_ID are pure slices of Instruction_ID, so they are 0 whenever IF/ID holds a bubble.
- No combinational path from Stall, Flush or BranchTaken to any IF/ID output.

Test Plan:
- Reset then release with memory holding 32'h2008_0005 (addi) at 0x00400000.
  - Expect IMemAddr=0x00400000 during reset.
  - After the 1st edge: Instruction_ID=32'h2008_0005, OP_ID=6'h08, PCPlus4_ID=0x00400004, Valid_ID=1, IMemAddr=0x00400004, FetchCount=1.
- Stall high for 3 edges mid-stream: PC, Instruction_ID and FetchCount unchanged. On release the next edge resumes at PC+4 with no instruction skipped or duplicated.
- BranchTaken=1, BranchTarget=0x00400040 together with Stall=1: next edge PC=0x00400040, Valid_ID=0, OP_ID=0, AlignErr=0. The following edge loads mem[0x00400040].
- BranchTarget=0x00400042 with BranchTaken: PC=0x00400040, AlignErr=1 for exactly one cycle.
- Flush alone at PC=0x00400008: IF/ID becomes bubble, IMemAddr stays 0x00400008, and the next edge loads mem[0x00400008].
- Force PC to 0xFFFFFFFC via redirect and run one Normal edge: IMemAddr=0x00000000, PCPlus4_ID=0x00000000. Then assert reset asynchronously between edges: outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's pipeline-control, program-memory and IF/ID signals.
// The slave view belongs to the fetch stage; the master view belongs to its surroundings.
interface fetch_if #(
    parameter int NBITS = 32
);
    logic             Stall;
    logic             Flush;
    logic             BranchTaken;
    logic [NBITS-1:0] BranchTarget;
    logic [NBITS-1:0] IMemData;
    logic [NBITS-1:0] IMemAddr;
    logic [NBITS-1:0] Instruction_ID;
    logic [NBITS-1:0] PCPlus4_ID;
    logic             Valid_ID;
    logic [5:0]       OP_ID;
    logic [4:0]       Rs_ID;
    logic [4:0]       Rt_ID;
    logic [4:0]       Rd_ID;
    logic [15:0]      Imm_ID;
    logic             AlignErr;
    logic [31:0]      FetchCount;

    modport slave (
        input  Stall, Flush, BranchTaken, BranchTarget, IMemData,
        output IMemAddr, Instruction_ID, PCPlus4_ID, Valid_ID,
               OP_ID, Rs_ID, Rt_ID, Rd_ID, Imm_ID, AlignErr, FetchCount
    );

    modport master (
        output Stall, Flush, BranchTaken, BranchTarget, IMemData,
        input  IMemAddr, Instruction_ID, PCPlus4_ID, Valid_ID,
               OP_ID, Rs_ID, Rt_ID, Rd_ID, Imm_ID, AlignErr, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives program memory and holds the IF/ID register.
// Per-edge priority is redirect, then flush, then stall, then a normal sequential fetch.
module fetch_stage #(
    parameter int               NBITS    = 32,
    parameter logic [NBITS-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.slave  bus
);
    logic [NBITS-1:0] pc_q,        pc_d;
    logic [NBITS-1:0] instr_q,     instr_d;
    logic [NBITS-1:0] pc_plus4_q,  pc_plus4_d;
    logic             valid_q,     valid_d;
    logic             align_err_q, align_err_d;
    logic [31:0]      fetch_cnt_q, fetch_cnt_d;
    logic [NBITS-1:0] pc_next_seq;

    assign pc_next_seq = pc_q + NBITS'(4);

    always_comb begin
        // NOTE: every variable gets a hold value first, so no branch can leave one
        // unassigned and infer a latch.
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        align_err_d = 1'b0;
        fetch_cnt_d = fetch_cnt_q;

        if (bus.BranchTaken) begin
            pc_d        = {bus.BranchTarget[NBITS-1:2], 2'b00};
            instr_d     = '0;
            pc_plus4_d  = '0;
            valid_d     = 1'b0;
            align_err_d = |bus.BranchTarget[1:0];
        end else if (bus.Flush) begin
            instr_d    = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!bus.Stall) begin
            pc_d        = pc_next_seq;
            instr_d     = bus.IMemData;
            pc_plus4_d  = pc_next_seq;
            valid_d     = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // The all-zero bubble word is sll $0,$0,0, an architectural NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.IMemAddr       = pc_q;
    assign bus.Instruction_ID = instr_q;
    assign bus.PCPlus4_ID     = pc_plus4_q;
    assign bus.Valid_ID       = valid_q;
    assign bus.AlignErr       = align_err_q;
    assign bus.FetchCount     = fetch_cnt_q;
    assign bus.OP_ID          = instr_q[31:26];
    assign bus.Rs_ID          = instr_q[25:21];
    assign bus.Rt_ID          = instr_q[20:16];
    assign bus.Rd_ID          = instr_q[15:11];
    assign bus.Imm_ID         = instr_q[15:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall, flush, redirect, misaligned redirect, PC wrap, async reset.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_if #(.NBITS(32)) bus ();

    fetch_stage #(.NBITS(32), .RESET_PC(32'h0040_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents, read combinationally from IMemAddr.
    always_comb begin
        case (bus.IMemAddr)
            32'h0040_0000: bus.IMemData = 32'h2008_0005;
            32'h0040_0004: bus.IMemData = 32'h2009_0007;
            32'h0040_0008: bus.IMemData = 32'h012A_5820;
            32'h0040_000C: bus.IMemData = 32'h8D0C_0004;
            32'h0040_0040: bus.IMemData = 32'h1000_FFFF;
            default:       bus.IMemData = 32'h3C01_BEEF;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bus.Stall        = 1'b0;
        bus.Flush        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = '0;
        #12;
        cmp("reset_imemaddr", bus.IMemAddr, 32'h0040_0000);
        cmp("reset_instr", bus.Instruction_ID, 32'h0);
        cmp("reset_valid", 32'(bus.Valid_ID), 32'h0);
        cmp("reset_count", bus.FetchCount, 32'h0);
        cmp("reset_alignerr", 32'(bus.AlignErr), 32'h0);
        step();
        cmp("reset_hold_imemaddr", bus.IMemAddr, 32'h0040_0000);
        reset = 1'b1;
        step();
        cmp("first_instr", bus.Instruction_ID, 32'h2008_0005);
        cmp("first_op", 32'(bus.OP_ID), 32'h08);
        cmp("first_rt", 32'(bus.Rt_ID), 32'h08);
        cmp("first_imm", 32'(bus.Imm_ID), 32'h0005);
        cmp("first_pcplus4", bus.PCPlus4_ID, 32'h0040_0004);
        cmp("first_valid", 32'(bus.Valid_ID), 32'h1);
        cmp("first_imemaddr", bus.IMemAddr, 32'h0040_0004);
        cmp("first_count", bus.FetchCount, 32'h1);
    endtask

    task automatic test_stall();
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("stall_imemaddr", bus.IMemAddr, 32'h0040_0004);
            cmp("stall_instr", bus.Instruction_ID, 32'h2008_0005);
            cmp("stall_count", bus.FetchCount, 32'h1);
            cmp("stall_valid", 32'(bus.Valid_ID), 32'h1);
        end
        bus.Stall = 1'b0;
        step();
        cmp("unstall_instr", bus.Instruction_ID, 32'h2009_0007);
        cmp("unstall_pcplus4", bus.PCPlus4_ID, 32'h0040_0008);
        cmp("unstall_imemaddr", bus.IMemAddr, 32'h0040_0008);
        cmp("unstall_count", bus.FetchCount, 32'h2);
    endtask

    task automatic test_flush();
        bus.Flush = 1'b1;
        step();
        cmp("flush_instr", bus.Instruction_ID, 32'h0);
        cmp("flush_pcplus4", bus.PCPlus4_ID, 32'h0);
        cmp("flush_valid", 32'(bus.Valid_ID), 32'h0);
        cmp("flush_op", 32'(bus.OP_ID), 32'h0);
        cmp("flush_imemaddr", bus.IMemAddr, 32'h0040_0008);
        cmp("flush_count", bus.FetchCount, 32'h2);
        bus.Flush = 1'b0;
        step();
        cmp("refetch_instr", bus.Instruction_ID, 32'h012A_5820);
        cmp("refetch_rs", 32'(bus.Rs_ID), 32'd9);
        cmp("refetch_rt", 32'(bus.Rt_ID), 32'd10);
        cmp("refetch_rd", 32'(bus.Rd_ID), 32'd11);
        cmp("refetch_pcplus4", bus.PCPlus4_ID, 32'h0040_000C);
        cmp("refetch_count", bus.FetchCount, 32'h3);
    endtask

    task automatic test_branch_over_stall();
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h0040_0040;
        bus.Stall        = 1'b1;
        step();
        cmp("br_imemaddr", bus.IMemAddr, 32'h0040_0040);
        cmp("br_valid", 32'(bus.Valid_ID), 32'h0);
        cmp("br_op", 32'(bus.OP_ID), 32'h0);
        cmp("br_alignerr", 32'(bus.AlignErr), 32'h0);
        cmp("br_count", bus.FetchCount, 32'h3);
        bus.BranchTaken = 1'b0;
        bus.Stall       = 1'b0;
        step();
        cmp("br_target_instr", bus.Instruction_ID, 32'h1000_FFFF);
        cmp("br_target_pcplus4", bus.PCPlus4_ID, 32'h0040_0044);
        cmp("br_target_count", bus.FetchCount, 32'h4);
    endtask

    task automatic test_misaligned();
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h0040_0042;
        step();
        cmp("mis_imemaddr", bus.IMemAddr, 32'h0040_0040);
        cmp("mis_alignerr", 32'(bus.AlignErr), 32'h1);
        bus.BranchTaken = 1'b0;
        step();
        cmp("mis_alignerr_clear", 32'(bus.AlignErr), 32'h0);
        cmp("mis_instr", bus.Instruction_ID, 32'h1000_FFFF);
        cmp("mis_count", bus.FetchCount, 32'h5);
    endtask

    task automatic test_wrap_and_async_reset();
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'hFFFF_FFFC;
        step();
        cmp("wrap_redirect", bus.IMemAddr, 32'hFFFF_FFFC);
        bus.BranchTaken = 1'b0;
        step();
        cmp("wrap_imemaddr", bus.IMemAddr, 32'h0000_0000);
        cmp("wrap_pcplus4", bus.PCPlus4_ID, 32'h0000_0000);
        cmp("wrap_instr", bus.Instruction_ID, 32'h3C01_BEEF);
        cmp("wrap_valid", 32'(bus.Valid_ID), 32'h1);
        cmp("wrap_count", bus.FetchCount, 32'h6);
        #2;
        reset = 1'b0;
        #1;
        cmp("async_imemaddr", bus.IMemAddr, 32'h0040_0000);
        cmp("async_instr", bus.Instruction_ID, 32'h0);
        cmp("async_valid", 32'(bus.Valid_ID), 32'h0);
        cmp("async_count", bus.FetchCount, 32'h0);
        reset = 1'b1;
        step();
        cmp("post_reset_instr", bus.Instruction_ID, 32'h2008_0005);
        cmp("post_reset_count", bus.FetchCount, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stall();
        test_flush();
        test_branch_over_stall();
        test_misaligned();
        test_wrap_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
